// File: rtl/phase_accumulator_mc.sv
// Multi-channel time-multiplexed phase accumulator (DDS/NCO), round-robin AXI-stream output.
// Optional phase-coherent restart port enabled by defining PHASE_ACCUMULATOR_MC_SYNC_EN.
module phase_accumulator_mc #(
    parameter int unsigned           WIDTH              = 32,
    parameter int unsigned           CHANNELS           = 4,
    parameter int unsigned           CH_WIDTH           = 2,
    parameter logic [WIDTH-1:0]      INITIAL_PHASE      = '0,
    parameter logic [WIDTH-1:0]      INITIAL_PHASE_STEP = '0
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PHASE_ACCUMULATOR_MC_SYNC_EN
    input  logic                sync,
`endif
    input  logic [WIDTH-1:0]    input_phase_tdata,
    input  logic [CH_WIDTH-1:0] input_phase_tdest,
    input  logic                input_phase_tvalid,
    output logic                input_phase_tready,
    input  logic [WIDTH-1:0]    input_phase_step_tdata,
    input  logic [CH_WIDTH-1:0] input_phase_step_tdest,
    input  logic                input_phase_step_tvalid,
    output logic                input_phase_step_tready,
    output logic [WIDTH-1:0]    output_phase_tdata,
    output logic [CH_WIDTH-1:0] output_phase_tdest,
    output logic                output_phase_tvalid,
    input  logic                output_phase_tready
);

    logic [WIDTH-1:0]    phase_reg [CHANNELS];
    logic [WIDTH-1:0]    step_reg  [CHANNELS];
    logic [CH_WIDTH-1:0] ptr;
    logic [WIDTH-1:0]    cur_phase;
    logic [WIDTH-1:0]    cur_step;
    logic                advance;
    logic                sync_w;

`ifdef PHASE_ACCUMULATOR_MC_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    // Loads are never back-pressured; ready simply mirrors the reset state.
    assign input_phase_tready      = rst;
    assign input_phase_step_tready = rst;

    assign advance = !output_phase_tvalid || output_phase_tready;

    always_comb begin
        cur_phase = '0;
        cur_step  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ptr == CH_WIDTH'(c)) begin
                cur_phase = phase_reg[c];
                cur_step  = step_reg[c];
            end
        end
    end

    // Per-channel priority: sync, then phase load, then accumulation.
    // Out-of-range tdest matches no channel and is silently discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                phase_reg[c] <= INITIAL_PHASE;
                step_reg[c]  <= INITIAL_PHASE_STEP;
            end
            ptr                 <= '0;
            output_phase_tdata  <= '0;
            output_phase_tdest  <= '0;
            output_phase_tvalid <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (sync_w)
                    phase_reg[c] <= INITIAL_PHASE;
                else if (input_phase_tvalid && input_phase_tdest == CH_WIDTH'(c))
                    phase_reg[c] <= input_phase_tdata;
                else if (advance && ptr == CH_WIDTH'(c))
                    phase_reg[c] <= cur_phase + cur_step;

                if (input_phase_step_tvalid && input_phase_step_tdest == CH_WIDTH'(c))
                    step_reg[c] <= input_phase_step_tdata;
            end

            if (sync_w) begin
                ptr                 <= '0;
                output_phase_tvalid <= 1'b0;
            end else if (advance) begin
                output_phase_tdata  <= cur_phase;
                output_phase_tdest  <= ptr;
                output_phase_tvalid <= 1'b1;
                ptr <= (ptr == CH_WIDTH'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Directed self-checking bench for phase_accumulator_mc (4 channels, 3-bit tdest, INITIAL_PHASE=0x10).
module tb_phase_accumulator_mc;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CH_WIDTH = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                sync = 1'b0;
    logic [WIDTH-1:0]    ip_tdata = '0;
    logic [CH_WIDTH-1:0] ip_tdest = '0;
    logic                ip_tvalid = 1'b0;
    logic                ip_tready;
    logic [WIDTH-1:0]    is_tdata = '0;
    logic [CH_WIDTH-1:0] is_tdest = '0;
    logic                is_tvalid = 1'b0;
    logic                is_tready;
    logic [WIDTH-1:0]    o_tdata;
    logic [CH_WIDTH-1:0] o_tdest;
    logic                o_tvalid;
    logic                o_tready = 1'b0;

    int unsigned total = 0;
    int unsigned bad   = 0;

    phase_accumulator_mc #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .CH_WIDTH(CH_WIDTH),
        .INITIAL_PHASE(32'h10),
        .INITIAL_PHASE_STEP(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef PHASE_ACCUMULATOR_MC_SYNC_EN
        .sync(sync),
`endif
        .input_phase_tdata(ip_tdata),
        .input_phase_tdest(ip_tdest),
        .input_phase_tvalid(ip_tvalid),
        .input_phase_tready(ip_tready),
        .input_phase_step_tdata(is_tdata),
        .input_phase_step_tdest(is_tdest),
        .input_phase_step_tvalid(is_tvalid),
        .input_phase_step_tready(is_tready),
        .output_phase_tdata(o_tdata),
        .output_phase_tdest(o_tdest),
        .output_phase_tvalid(o_tvalid),
        .output_phase_tready(o_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_word(input string tag, input int unsigned d, input logic [31:0] v);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(o_tvalid), 32'd1);
        chk({tag, ".dest"},  32'(o_tdest),  32'(d));
        chk({tag, ".data"},  o_tdata,       v);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"},   32'(o_tvalid),  32'd0);
        chk({tag, ".data"},    o_tdata,        32'd0);
        chk({tag, ".dest"},    32'(o_tdest),   32'd0);
        chk({tag, ".p_ready"}, 32'(ip_tready), 32'd0);
        chk({tag, ".s_ready"}, 32'(is_tready), 32'd0);
    endtask

    task automatic load(input logic pv, input int unsigned pd, input logic [31:0] pdata,
                        input logic sv, input int unsigned sd, input logic [31:0] sdata);
        ip_tvalid = pv; ip_tdest = CH_WIDTH'(pd); ip_tdata = pdata;
        is_tvalid = sv; is_tdest = CH_WIDTH'(sd); is_tdata = sdata;
    endtask

    int unsigned      wrap_dest [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [31:0]      wrap_data [8] = '{32'd6, 32'd9, 32'd12, 32'h8000_0000,
                                        32'd8, 32'd12, 32'd16, 32'h0000_0000};
    int unsigned      ld_dest   [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic [31:0]      ld_data   [9] = '{32'd10, 32'd15, 32'd20, 32'h8000_0000,
                                        32'h1234, 32'd18, 32'd24, 32'h0, 32'h1236};

    initial begin
        // Reset state
        #1;
        chk_reset("rst0");
        @(negedge clk);
        @(negedge clk);

        // Release, step 0: every channel sits at INITIAL_PHASE
        rst = 1'b1;
        o_tready = 1'b1;
        #1;
        chk("rel.p_ready", 32'(ip_tready), 32'd1);
        chk("rel.s_ready", 32'(is_tready), 32'd1);
        next_word("init0", 0, 32'h10);
        next_word("init1", 1, 32'h10);
        next_word("init2", 2, 32'h10);
        next_word("init3", 3, 32'h10);
        next_word("init4", 0, 32'h10);

        // Mid-stream reset is immediate
        rst = 1'b0;
        #1;
        chk_reset("rst1");
        @(negedge clk);

        // Release into a stall; load phases 0 and steps 1..4 while output is held
        rst = 1'b1;
        o_tready = 1'b0;
        next_word("first", 0, 32'h10);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            load(1'b1, c, 32'h0, 1'b1, c, 32'(c + 1));
            next_word("stall", 0, 32'h10);
        end
        load(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        next_word("stall5", 0, 32'h10);
        o_tready = 1'b1;

        // Resume: ch1, ch2, ch3, ch0, ... each advancing by its own step
        for (int unsigned k = 0; k < 12; k++)
            next_word("steps", (k + 1) % 4, 32'((k / 4) * ((k + 1) % 4 + 1)));

        // Modulo wrap on ch0
        load(1'b1, 0, 32'h8000_0000, 1'b1, 0, 32'h8000_0000);
        for (int unsigned k = 0; k < 8; k++) begin
            next_word("wrap", wrap_dest[k], wrap_data[k]);
            if (k == 0) load(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        end

        // Load collides with ch1 accumulation; out-of-range tdest discarded
        load(1'b1, 1, 32'h1234, 1'b1, 5, 32'hFFFF);
        for (int unsigned k = 0; k < 9; k++) begin
            next_word("load", ld_dest[k], ld_data[k]);
            if (k == 0) load(1'b1, 5, 32'hDEAD, 1'b0, 0, 32'h0);
            if (k == 1) load(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        end

`ifdef PHASE_ACCUMULATOR_MC_SYNC_EN
        sync = 1'b1;
        @(negedge clk);
        chk("sync.valid", 32'(o_tvalid), 32'd0);
        sync = 1'b0;
        next_word("sync0", 0, 32'h10);
        next_word("sync1", 1, 32'h10);
        next_word("sync2", 2, 32'h10);
        next_word("sync3", 3, 32'h10);
        next_word("sync4", 0, 32'h8000_0010);
        next_word("sync5", 1, 32'h12);
`endif

        // Reset again with steps loaded: all state back to initial values
        rst = 1'b0;
        #1;
        chk_reset("rst2");
        @(negedge clk);
        rst = 1'b1;
        next_word("post0", 0, 32'h10);
        next_word("post1", 1, 32'h10);
        next_word("post2", 2, 32'h10);
        next_word("post3", 3, 32'h10);
        next_word("post4", 0, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_accumulator_mc.md
Name: phase_accumulator_mc

Overview:
- Multi-channel, time-multiplexed phase accumulator for DDS/NCO chains.
- Holds CHANNELS independent phase/step register pairs and emits phases round-robin on one AXI-stream output, tagged with the channel index.
- Per-channel phase and step are loaded over AXI-stream inputs addressed by tdest.
- Feeds a shared phase-to-amplitude stage.

Parameters:
WIDTH, 32, phase and step width in bits
CHANNELS, 4, number of channels (2 to 2**CH_WIDTH)
CH_WIDTH, 2, channel index width
INITIAL_PHASE, 0, phase of every channel after reset
INITIAL_PHASE_STEP, 0, step of every channel after reset

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
input_phase_tdata  input  WIDTH  phase load value
input_phase_tdest  input  CH_WIDTH  target channel of phase load
input_phase_tvalid  input  1  phase load valid
input_phase_tready  output  1  phase load ready
input_phase_step_tdata  input  WIDTH  step load value
input_phase_step_tdest  input  CH_WIDTH  target channel of step load
input_phase_step_tvalid  input  1  step load valid
input_phase_step_tready  output  1  step load ready
output_phase_tdata  output  WIDTH  phase of channel output_phase_tdest
output_phase_tdest  output  CH_WIDTH  channel index of output word
output_phase_tvalid  output  1  output valid
output_phase_tready  input  1  output ready

Behaviour:
- Reset (rst low, asynchronous):
  - All phase_reg[c] = INITIAL_PHASE; all step_reg[c] = INITIAL_PHASE_STEP.
  - Channel pointer ptr = 0.
  - output_phase_tdata = 0, output_phase_tdest = 0, output_phase_tvalid = 0.
  - Both input treadys are 0 during reset.
- Input treadys are 1 in every cycle after reset release. Loads are never back-pressured.
- Output register update (one cycle latency) occurs when output_phase_tvalid == 0 or output_phase_tready == 1:
  - output_phase_tdata <= phase_reg[ptr]; output_phase_tdest <= ptr; output_phase_tvalid <= 1.
  - phase_reg[ptr] <= phase_reg[ptr] + step_reg[ptr], modulo 2**WIDTH. Wrap-around is silent; no carry out.
  - ptr <= (ptr == CHANNELS-1) ? 0 : ptr + 1.
- First valid word appears on the first clock edge after reset release: channel 0, INITIAL_PHASE.
- Stall (tvalid=1, tready=0): output registers, ptr and all phase_reg accumulation are frozen. Output data is stable per AXI-stream rules.
- Phase load (input_phase_tvalid & tready):
  - phase_reg[tdest] <= tdata.
  - If the load hits the channel being accumulated in the same cycle, the load wins and the accumulation result is discarded.
  - A load never alters the word already in the output register. It appears the next time that channel is presented.
- Step load (input_phase_step_tvalid & tready):
  - step_reg[tdest] <= tdata.
  - A same-cycle accumulation on that channel uses the old step. The new step applies from the next accumulation.
- Phase and step loads to different or the same channels in one cycle are independent; both take effect.
- tdest >= CHANNELS on either input: the word is accepted (tready = 1) and discarded. No state changes.
- Output sequence at full throughput: ch0, ch1, …, ch(CHANNELS-1), ch0, … Each channel advances by one step per CHANNELS output transfers.
- Reset asserted mid-stream: immediate return to the reset state. Any in-flight output word is dropped.

Optional Feature:
- Macro: PHASE_ACCUMULATOR_MC_SYNC_EN
- Defined:
  - Adds port sync  input  1.
  - On a cycle with sync = 1, all phase_reg[c] <= INITIAL_PHASE and ptr <= 0. Step registers are unchanged.
  - Same-cycle phase loads and accumulations are overridden by sync.
  - output_phase_tvalid <= 0 for that cycle, so the next valid word is ch0 at INITIAL_PHASE. This gives phase-coherent restart across channels.
- Not defined: no sync port; behaviour as above.

Test Plan:
- Reset release, tready=1, no loads, INITIAL_PHASE=0x10 -> first valid word ch0=0x10, then ch1=0x10, ch2=0x10, ch3=0x10, ch0=0x10 (step 0).
- Steps ch0=1, ch1=2, ch2=3, ch3=4; tready=1 -> ch0 sequence 0,1,2,…; ch3 sequence 0,4,8,…; tdest cycles 0,1,2,3.
- Step ch0=0x80000000, phase ch0=0x80000000 -> next ch0 output 0x80000000, following ch0 output 0x00000000 (wrap).
- tready held 0 for 5 cycles mid-stream -> tdata/tdest stable; after release, sequence resumes with no skipped or repeated channel.
- Phase load ch1=0x1234 in the same cycle ch1 accumulates -> next ch1 output 0x1234. tdest=5 load -> no channel changes.
- With PHASE_ACCUMULATOR_MC_SYNC_EN, sync pulse after 7 transfers -> one cycle tvalid=0, then ch0 at INITIAL_PHASE; steps retained.
